// File: rtl/i2c_slave_if.sv
// Bus-side and byte-stream signals of the I2C target, grouped so the
// target and whoever drives it share one bundle.
interface i2c_slave_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic [7:0] tx_data_i;
  logic       tx_load_o;
  logic       busy_o;

  modport slave (
    input  scl_i, sda_i, rx_ready_i, tx_data_i,
    output sda_oe_o, rx_data_o, rx_valid_o, tx_load_o, busy_o
  );

  modport master (
    output scl_i, sda_i, rx_ready_i, tx_data_i,
    input  sda_oe_o, rx_data_o, rx_valid_o, tx_load_o, busy_o
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address. SCL/SDA are oversampled by the core
// clock; SDA is only ever pulled low or released (open drain).
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h25
) (
  input  logic        i2c_core_clk_i,
  input  logic        i2c_core_rst_i,
  i2c_slave_if.slave  bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] RX_BYTE   = 3'd3;
  localparam logic [2:0] RX_ACK    = 3'd4;
  localparam logic [2:0] TX_BYTE   = 3'd5;
  localparam logic [2:0] TX_ACK    = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  logic [1:0] sclSync_q, sdaSync_q;
  logic       sclDly_q, sdaDly_q;
  logic       scl, sda, sclRise, sclFall, startDet, stopDet;

  logic [2:0] state_q, state_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic [6:0] shift_q, shift_d;
  logic [6:0] txShift_q, txShift_d;
  logic       ackPhase_q, ackPhase_d;
  logic       rw_q, rw_d;
  logic       accept_q, accept_d;
  logic       sdaOe_q, sdaOe_d;
  logic [7:0] rxData_q, rxData_d;
  logic       rxValid_q, rxValid_d;
  logic       txLoad_q, txLoad_d;
  logic       busy_q, busy_d;

  // Two-flop synchronizers plus one delay stage for edge detection; idle bus is high.
  always_ff @(posedge i2c_core_clk_i) begin
    if (i2c_core_rst_i) begin
      sclSync_q <= 2'b11;
      sdaSync_q <= 2'b11;
      sclDly_q  <= 1'b1;
      sdaDly_q  <= 1'b1;
    end else begin
      sclSync_q <= {sclSync_q[0], bus.scl_i};
      sdaSync_q <= {sdaSync_q[0], bus.sda_i};
      sclDly_q  <= sclSync_q[1];
      sdaDly_q  <= sdaSync_q[1];
    end
  end

  assign scl      = sclSync_q[1];
  assign sda      = sdaSync_q[1];
  assign sclRise  = scl & ~sclDly_q;
  assign sclFall  = ~scl & sclDly_q;
  assign startDet = scl & sdaDly_q & ~sda;
  assign stopDet  = scl & ~sdaDly_q & sda;

  // Protocol FSM: bits sampled on SCL rise, SDA drive updated only on SCL fall.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    txShift_d  = txShift_q;
    ackPhase_d = ackPhase_q;
    rw_d       = rw_q;
    accept_d   = accept_q;
    sdaOe_d    = sdaOe_q;
    rxData_d   = rxData_q;
    rxValid_d  = 1'b0;
    txLoad_d   = 1'b0;
    busy_d     = busy_q;

    if (stopDet) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      sdaOe_d = 1'b0;
    end else if (startDet) begin
      state_d  = ADDR;
      bitCnt_d = 3'd7;
    end else begin
      case (state_q)
        ADDR: begin
          if (sclRise) begin
            shift_d  = {shift_q[5:0], sda};
            bitCnt_d = bitCnt_q - 3'd1;
            if (bitCnt_q == 3'd0) begin
              if (shift_q == SLAVE_ADDR) begin
                state_d    = ADDR_ACK;
                busy_d     = 1'b1;
                rw_d       = sda;
                ackPhase_d = 1'b0;
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (sclFall) begin
            if (!ackPhase_q) begin
              sdaOe_d    = 1'b1;
              ackPhase_d = 1'b1;
            end else begin
              bitCnt_d = 3'd7;
              if (rw_q) begin
                txShift_d = bus.tx_data_i[6:0];
                txLoad_d  = 1'b1;
                sdaOe_d   = ~bus.tx_data_i[7];
                state_d   = TX_BYTE;
              end else begin
                sdaOe_d = 1'b0;
                state_d = RX_BYTE;
              end
            end
          end
        end
        RX_BYTE: begin
          if (sclRise) begin
            shift_d  = {shift_q[5:0], sda};
            bitCnt_d = bitCnt_q - 3'd1;
            if (bitCnt_q == 3'd0) begin
              rxData_d   = {shift_q, sda};
              rxValid_d  = 1'b1;
              accept_d   = bus.rx_ready_i;
              ackPhase_d = 1'b0;
              state_d    = RX_ACK;
            end
          end
        end
        RX_ACK: begin
          if (sclFall) begin
            if (!ackPhase_q) begin
              sdaOe_d    = accept_q;
              ackPhase_d = 1'b1;
            end else begin
              sdaOe_d  = 1'b0;
              bitCnt_d = 3'd7;
              state_d  = accept_q ? RX_BYTE : WAIT_STOP;
            end
          end
        end
        TX_BYTE: begin
          if (sclFall) begin
            if (bitCnt_q == 3'd0) begin
              sdaOe_d    = 1'b0;
              ackPhase_d = 1'b0;
              state_d    = TX_ACK;
            end else begin
              bitCnt_d  = bitCnt_q - 3'd1;
              sdaOe_d   = ~txShift_q[6];
              txShift_d = {txShift_q[5:0], 1'b0};
            end
          end
        end
        TX_ACK: begin
          if (sclRise) begin
            if (sda) state_d = WAIT_STOP;
            else ackPhase_d = 1'b1;
          end else if (sclFall && ackPhase_q) begin
            txShift_d = bus.tx_data_i[6:0];
            txLoad_d  = 1'b1;
            sdaOe_d   = ~bus.tx_data_i[7];
            bitCnt_d  = 3'd7;
            state_d   = TX_BYTE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and output registers; reset releases SDA and parks the FSM in IDLE.
  always_ff @(posedge i2c_core_clk_i) begin
    if (i2c_core_rst_i) begin
      state_q    <= IDLE;
      bitCnt_q   <= 3'd7;
      shift_q    <= 7'd0;
      txShift_q  <= 7'd0;
      ackPhase_q <= 1'b0;
      rw_q       <= 1'b0;
      accept_q   <= 1'b0;
      sdaOe_q    <= 1'b0;
      rxData_q   <= 8'h00;
      rxValid_q  <= 1'b0;
      txLoad_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      txShift_q  <= txShift_d;
      ackPhase_q <= ackPhase_d;
      rw_q       <= rw_d;
      accept_q   <= accept_d;
      sdaOe_q    <= sdaOe_d;
      rxData_q   <= rxData_d;
      rxValid_q  <= rxValid_d;
      txLoad_q   <= txLoad_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.sda_oe_o   = sdaOe_q;
  assign bus.rx_data_o  = rxData_q;
  assign bus.rx_valid_o = rxValid_q;
  assign bus.tx_load_o  = txLoad_q;
  assign bus.busy_o     = busy_q;

endmodule
